axicb_cpl_arbiter: RTL and testbench

Burst-locking round-robin arbiter for the completion path (R or B channel) that returns to one master. It selects one slave completion channel, holds the grant until the last beat of that burst has been accepted, and forwards the selected channel to the master side with zero added latency. It also counts beats against the expected burst length supplied by the ordering logic, flags mismatches, and emits a per-burst done pulse that advances the ordering logic's own arbiter.

---
 rtl/axicb_cpl_arbiter.sv | 121 ++++++++++++
 tb/tb_axicb_cpl_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axicb_cpl_arbiter.sv
// Completion-path arbiter: round-robin pick among slave R/B channels, locked for a
// whole burst, zero-latency forwarding to the master, with beat counting against exp_len.
module axicb_cpl_arbiter #(
  parameter int SLV_NB    = 4,
  parameter int CCH_W     = 8,
  parameter int LEN_CHECK = 1
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic [SLV_NB-1:0]       c_valid,
  input  logic [SLV_NB-1:0]       c_last,
  input  logic [CCH_W*SLV_NB-1:0] c_ch,
  output logic [SLV_NB-1:0]       c_ready,
  input  logic [7:0]              exp_len,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [CCH_W-1:0]        m_ch,
  output logic [SLV_NB-1:0]       grant,
  output logic                    busy,
  output logic                    cpl_done,
  output logic                    len_err
);

  localparam int          IW = $clog2(SLV_NB);
  localparam int unsigned NB = SLV_NB;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     prio, prio_nxt, pick_idx, gnt_idx_r, cur_idx, sidx;
  logic [SLV_NB-1:0] pick, grant_r;
  logic [7:0]        exp_r, exp_cur;
  logic [8:0]        cnt, beat_cnt, exp_p1;
  logic              hs, found, err_det, err_seen, prior_seen;
  logic              cpl_done_r, len_err_r;
  int unsigned       slot;

  // Round-robin pick: first requester at or after prio, scanning upward with wrap.
  always_comb begin
    pick     = '0;
    pick_idx = prio;
    found    = 1'b0;
    slot     = 0;
    sidx     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      slot = 32'(prio) + i;
      if (slot >= NB) slot = slot - NB;
      sidx = IW'(slot);
      if (!found && c_valid[sidx]) begin
        pick[sidx] = 1'b1;
        pick_idx   = sidx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!srst) grant = (state == LOCKED) ? grant_r : pick;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_ch    = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (grant[j]) begin
        m_valid = m_valid | c_valid[j];
        m_last  = m_last | c_last[j];
        m_ch    = m_ch | c_ch[j*CCH_W +: CCH_W];
      end
    end
    c_ready = grant & {SLV_NB{m_ready}};
  end

  // Beat count of the beat being handshaken now; a non-last beat that reaches
  // exp+1 is an overrun, a last beat that misses exp+1 is a short/long burst.
  always_comb begin
    hs         = m_valid & m_ready;
    cur_idx    = (state == LOCKED) ? gnt_idx_r : pick_idx;
    prio_nxt   = (32'(cur_idx) == NB - 1) ? '0 : cur_idx + IW'(1);
    exp_cur    = (state == LOCKED) ? exp_r : exp_len;
    exp_p1     = {1'b0, exp_cur} + 9'd1;
    beat_cnt   = (state == IDLE) ? 9'd1 : (cnt[8] ? cnt : cnt + 9'd1);
    err_det    = hs & (m_last ? (beat_cnt != exp_p1) : (beat_cnt == exp_p1));
    prior_seen = (state == LOCKED) & err_seen;
    state_nxt  = state;
    if (hs) state_nxt = m_last ? IDLE : LOCKED;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state      <= IDLE;
      prio       <= '0;
      cnt        <= '0;
      err_seen   <= 1'b0;
      cpl_done_r <= 1'b0;
      len_err_r  <= 1'b0;
      grant_r    <= '0;
      gnt_idx_r  <= '0;
      exp_r      <= '0;
    end else begin
      state      <= state_nxt;
      cpl_done_r <= hs & m_last;
      len_err_r  <= (LEN_CHECK != 0) && err_det && !prior_seen;
      if (hs) begin
        cnt      <= beat_cnt;
        err_seen <= err_det | prior_seen;
        if (state == IDLE) begin
          grant_r   <= pick;
          gnt_idx_r <= pick_idx;
          exp_r     <= exp_len;
        end
        if (m_last) prio <= prio_nxt;
      end
    end
  end

  assign busy     = (state == LOCKED);
  assign cpl_done = cpl_done_r;
  assign len_err  = len_err_r;

endmodule

// File: tb/tb_axicb_cpl_arbiter.sv
// Directed bench for axicb_cpl_arbiter: reactive slave drivers, a per-cycle reference
// model of the arbitration rules, and literal checks on key cycles.
module tb_axicb_cpl_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           srst;
  logic [N-1:0]   c_valid, c_last, c_ready, grant;
  logic [W*N-1:0] c_ch;
  logic [7:0]     exp_len;
  logic           m_valid, m_ready, m_last, busy, cpl_done, len_err;
  logic [W-1:0]   m_ch;

  always #5 clk = ~clk;

  axicb_cpl_arbiter #(.SLV_NB(N), .CCH_W(W), .LEN_CHECK(1)) dut (
    .aclk(clk), .srst(srst), .c_valid(c_valid), .c_last(c_last), .c_ch(c_ch),
    .c_ready(c_ready), .exp_len(exp_len), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_ch(m_ch), .grant(grant), .busy(busy),
    .cpl_done(cpl_done), .len_err(len_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int rem[N], beat[N], reload[N], reload_len[N];
  logic [N-1:0] hs_cap = '0;
  int hs_total = 0, cpl_total = 0, err_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive();
    for (int j = 0; j < N; j++) begin
      c_valid[j]       = (rem[j] > 0);
      c_last[j]        = (rem[j] == 1);
      c_ch[j*W +: W]   = 8'((j << 6) | (beat[j] & 63));
    end
  endtask

  // Apply the handshakes seen at the previous negedge, just after the clock edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) begin
      if (hs_cap[j]) begin
        rem[j]--;
        beat[j]++;
        if (rem[j] == 0 && reload[j] > 0) begin
          reload[j]--;
          rem[j] = reload_len[j];
        end
      end
    end
  endtask

  task automatic tick();
    cycle();
    drive();
    #2;
  endtask

  task automatic drain();
    int b;
    int left;
    b = 0;
    left = 1;
    while (left > 0 && b < 200) begin
      cycle();
      drive();
      b++;
      left = 0;
      for (int j = 0; j < N; j++) left += rem[j] + reload[j];
    end
    check("drain_bound", left, 0);
    repeat (2) tick();
  endtask

  // Reference model: one locked slave or none, integer priority pointer, beat count.
  initial begin : model
    int lock, prio, cnt, expv, g, j, n, e;
    bit seen, e_cpl, e_err, hs, bad;
    logic [N-1:0] eg, ecr;
    logic emv, eml;
    logic [W-1:0] emch;
    lock = -1; prio = 0; cnt = 0; expv = 0; seen = 0; e_cpl = 0; e_err = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = -1;
      if (!srst) begin
        if (lock >= 0) g = lock;
        else
          for (int i = 0; i < N; i++) begin
            j = (prio + i) % N;
            if (g < 0 && c_valid[j]) g = j;
          end
      end
      eg   = (g >= 0) ? N'(1 << g) : '0;
      emv  = (g >= 0) ? c_valid[g] : 1'b0;
      eml  = (g >= 0) ? c_last[g] : 1'b0;
      emch = (g >= 0) ? c_ch[g*W +: W] : '0;
      ecr  = (g >= 0 && m_ready) ? eg : '0;
      check("mdl_grant", grant, eg);
      check("mdl_m_valid", m_valid, emv);
      check("mdl_m_last", m_last, eml);
      check("mdl_m_ch", m_ch, emch);
      check("mdl_c_ready", c_ready, ecr);
      check("mdl_busy", busy, lock >= 0);
      check("mdl_cpl_done", cpl_done, e_cpl);
      check("mdl_len_err", len_err, e_err);
      hs_cap = c_valid & c_ready;
      for (int i = 0; i < N; i++) hs_total += hs_cap[i];
      cpl_total += cpl_done;
      err_total += len_err;
      if (srst) begin
        lock = -1; prio = 0; cnt = 0; seen = 0; e_cpl = 0; e_err = 0;
      end else begin
        hs = emv && m_ready;
        e_cpl = hs && eml;
        e_err = 0;
        if (hs) begin
          n = (lock < 0) ? 1 : ((cnt + 1 > 256) ? 256 : cnt + 1);
          e = (lock < 0) ? int'(exp_len) : expv;
          if (lock < 0) begin seen = 0; expv = exp_len; end
          bad = eml ? (n != e + 1) : (n == e + 1);
          if (bad && !seen) e_err = 1;
          if (bad) seen = 1;
          cnt = n;
          if (eml) begin lock = -1; prio = (g + 1) % N; end
          else lock = g;
        end
      end
    end
  end

  logic [N-1:0] gexp[10] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1};
  logic         cexp[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin : stim
    int hs0, c0, e0;
    srst = 1'b1; m_ready = 1'b1; exp_len = 8'd1;
    for (int j = 0; j < N; j++) begin
      rem[j] = 2; beat[j] = 0; reload[j] = 1; reload_len[j] = 2;
    end
    drive();

    // Reset with every slave requesting
    repeat (2) begin
      tick();
      check("rst_grant", grant, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_c_ready", c_ready, 0);
    end

    // Fairness: 2-beat bursts from all slaves back to back
    cycle(); srst = 1'b0; drive();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin cycle(); drive(); end
      #2;
      check("fair_grant", grant, gexp[k]);
      check("fair_cpl", cpl_done, cexp[k]);
    end
    drain();

    // Lock: slave 1 4-beat burst, slave 0 arrives mid-burst
    cycle(); exp_len = 8'd3; rem[1] = 4; drive(); #2;
    check("lock_g1", grant, 4'b0010);
    cycle(); rem[0] = 1; exp_len = 8'd0; drive(); #2;
    check("lock_g2", grant, 4'b0010);
    check("lock_busy", busy, 1);
    tick(); check("lock_g3", grant, 4'b0010);
    tick(); check("lock_g4", grant, 4'b0010);
    check("lock_last", m_last, 1);
    tick(); check("lock_next", grant, 4'b0001);
    check("lock_cpl1", cpl_done, 1);
    tick(); check("lock_cpl0", cpl_done, 1);
    check("lock_err", len_err, 0);
    tick();

    // Backpressure: m_ready 1,0,1,0... over a 4-beat burst
    hs0 = hs_total; c0 = cpl_total; e0 = err_total;
    cycle(); exp_len = 8'd3; rem[2] = 4; m_ready = 1'b1; drive();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin cycle(); m_ready = (k % 2 == 0); drive(); end
      #2;
      check("bp_grant", grant, (k < 7) ? 4'b0100 : 4'b0000);
    end
    cycle(); m_ready = 1'b1; drive(); #2;
    tick();
    check("bp_hs", hs_total - hs0, 4);
    check("bp_cpl", cpl_total - c0, 1);
    check("bp_err", err_total - e0, 0);

    // Overrun: exp_len=1, last on beat 3
    cycle(); exp_len = 8'd1; rem[3] = 3; drive(); #2;
    check("ovr_e0", len_err, 0);
    tick(); check("ovr_e1", len_err, 0);
    tick(); check("ovr_e2", len_err, 1);
    tick(); check("ovr_e3", len_err, 0);
    check("ovr_cpl", cpl_done, 1);

    // Short burst: exp_len=3, last on beat 2
    cycle(); exp_len = 8'd3; rem[0] = 2; drive(); #2;
    tick(); check("short_e1", len_err, 0);
    tick(); check("short_e2", len_err, 1);
    check("short_cpl", cpl_done, 1);

    // Single beat
    cycle(); exp_len = 8'd0; rem[1] = 1; drive(); #2;
    check("single_grant", grant, 4'b0010);
    check("single_busy0", busy, 0);
    tick();
    check("single_busy1", busy, 0);
    check("single_cpl", cpl_done, 1);
    check("single_err", len_err, 0);

    // Reset mid-burst; slave 0 and 2 both pending afterwards, prio back at 0
    cycle(); exp_len = 8'd3; rem[2] = 4; drive(); #2;
    check("mrst_g", grant, 4'b0100);
    tick(); check("mrst_busy", busy, 1);
    cycle(); srst = 1'b1; rem[0] = 1; drive(); #2;
    check("mrst_grant", grant, 0);
    check("mrst_m_valid", m_valid, 0);
    check("mrst_c_ready", c_ready, 0);
    cycle(); srst = 1'b0; exp_len = 8'd0; drive(); #2;
    check("mrst_idle", busy, 0);
    check("mrst_cpl", cpl_done, 0);
    check("mrst_prio", grant, 4'b0001);
    cycle(); exp_len = 8'd1; drive(); #2;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
